// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit
//
// Executes one decoded RISC-V load at a time. The effective address is
// computed at accept, checked for natural alignment, and an aligned word read
// is issued on the data-memory port. When the read word returns, the addressed
// byte/halfword/word is extracted, sign- or zero-extended, and presented as a
// single-cycle register-file writeback. A misaligned access never touches
// memory and is reported instead as a single-cycle fault.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   req_valid      decode presents a load
//   req_ready      unit idle and able to accept a load
//   base           rs1 value
//   imm            12-bit signed I-type immediate
//   load_control   funct3 encoding: LB=0 LH=1 LW=2 LBU=4 LHU=5 (3,6,7 act as LB)
//   rd             destination register
//   mem_req_valid  read request valid (held until mem_req_ready)
//   mem_req_ready  memory accepts the request
//   mem_addr       word-aligned read address
//   mem_rsp_valid  read data valid (only honoured while waiting for it)
//   mem_rdata      read word
//   wb_valid       one-cycle writeback strobe
//   wb_rd          writeback register (holds between strobes)
//   wb_data        extended load result (holds between strobes)
//   fault_valid    one-cycle misaligned-load strobe
//   fault_addr     offending effective address (holds between strobes)
// -----------------------------------------------------------------------------
module load_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   base,
  input  logic [11:0]       imm,
  input  logic [2:0]        load_control,
  input  logic [4:0]        rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              fault_valid,
  output logic [ADDR_W-1:0] fault_addr
);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  // load_control codes (equal to funct3)
  localparam logic [2:0] LC_LH  = 3'd1;
  localparam logic [2:0] LC_LW  = 3'd2;
  localparam logic [2:0] LC_LBU = 3'd4;
  localparam logic [2:0] LC_LHU = 3'd5;

  // Access size, decoded once at accept so later stages only see size/sign
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] ea_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [4:0]        rd_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [4:0]        wb_rd_reg;
  logic [XLEN-1:0]   wb_data_reg;
  logic [ADDR_W-1:0] fault_addr_reg;

  logic              accept;
  logic              misaligned;
  logic              rsp_take;
  logic [ADDR_W-1:0] ea_sum;
  logic [1:0]        size_dec;
  logic              uns_dec;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [XLEN-1:0]   ext_data;

  // ---------------------------------------------------------------------------
  // Accept-side decode
  // ---------------------------------------------------------------------------
  assign req_ready = (state_reg == S_IDLE);
  assign accept    = req_valid && req_ready;

  // Effective address wraps silently modulo 2^ADDR_W.
  assign ea_sum = base[ADDR_W-1:0] + {{(ADDR_W-12){imm[11]}}, imm};

  always_comb begin
    size_dec = SZ_B;
    uns_dec  = 1'b0;
    case (load_control)
      LC_LH:  size_dec = SZ_H;
      LC_LW:  size_dec = SZ_W;
      LC_LBU: uns_dec  = 1'b1;
      LC_LHU: begin
        size_dec = SZ_H;
        uns_dec  = 1'b1;
      end
      default: ; // LB, and the unused codes 3/6/7 which behave as LB
    endcase
  end

  // Natural alignment: halfwords need ea[0]=0, words need ea[1:0]=0.
  assign misaligned = ((size_reg == SZ_H) && ea_reg[0]) ||
                      ((size_reg == SZ_W) && (ea_reg[1:0] != 2'b00));

  // A response is only taken while waiting for it; anything earlier
  // (including in the request-handshake cycle) is ignored.
  assign rsp_take = (state_reg == S_WAIT) && mem_rsp_valid;

  // ---------------------------------------------------------------------------
  // Lane extraction from the returned word
  // ---------------------------------------------------------------------------
  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lane[gi] = mem_rdata[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half_lane
      assign half_lane[gi] = mem_rdata[16*gi +: 16];
    end
  endgenerate

  always_comb begin
    sel_byte = byte_lane[ea_reg[1:0]];
    sel_half = half_lane[ea_reg[1]];
    case (size_reg)
      SZ_W:    ext_data = mem_rdata;
      SZ_H:    ext_data = {{(XLEN-16){~uns_reg & sel_half[15]}}, sel_half};
      default: ext_data = {{(XLEN-8){~uns_reg & sel_byte[7]}}, sel_byte};
    endcase
    // x0 is hard-wired to zero, so a load into it writes back zero.
    if (rd_reg == 5'd0) begin
      ext_data = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (req_valid) state_next = S_CHECK;
      S_CHECK: state_next = misaligned ? S_FAULT : S_REQ;
      S_REQ:   if (mem_req_ready) state_next = S_WAIT;
      S_WAIT:  if (mem_rsp_valid) state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      S_FAULT: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      ea_reg         <= '0;
      size_reg       <= SZ_B;
      uns_reg        <= 1'b0;
      rd_reg         <= 5'd0;
      mem_addr_reg   <= '0;
      wb_rd_reg      <= 5'd0;
      wb_data_reg    <= '0;
      fault_addr_reg <= '0;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        ea_reg   <= ea_sum;
        size_reg <= size_dec;
        uns_reg  <= uns_dec;
        rd_reg   <= rd;
      end

      // The request address is frozen on entry to REQ so it cannot move
      // while memory stalls the handshake.
      if (state_reg == S_CHECK) begin
        if (misaligned) begin
          fault_addr_reg <= ea_reg;
        end else begin
          mem_addr_reg <= {ea_reg[ADDR_W-1:2], 2'b00};
        end
      end

      if (rsp_take) begin
        wb_rd_reg   <= rd_reg;
        wb_data_reg <= ext_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req_valid = (state_reg == S_REQ);
  assign mem_addr      = mem_addr_reg;
  assign wb_valid      = (state_reg == S_WB);
  assign wb_rd         = wb_rd_reg;
  assign wb_data       = wb_data_reg;
  assign fault_valid   = (state_reg == S_FAULT);
  assign fault_addr    = fault_addr_reg;

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Executes decoded RISC-V load instructions. It consumes rs1 value, 12-bit immediate, 3-bit load_control and rd from the load decode stage.
- Computes the effective address, issues one word-aligned read to the data-memory port, waits for the response, then extracts and sign/zero-extends the addressed byte, halfword or word.
- Produces a single-cycle register-file writeback, or a misaligned-load fault.
- Sits between decode and the data-memory interface; handles one load in flight.

Parameters:
- XLEN, 32, data width of base operand, memory data and writeback data.
- ADDR_W, 32, effective-address width; equals XLEN.

Ports:
- clk  input  1  clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  decode presents a load.
- req_ready  output  1  unit can accept a load; 1 only in IDLE.
- base  input  XLEN  rs1 register value.
- imm  input  12  I-type immediate, signed.
- load_control  input  3  shared defines with values equal to funct3: `LB=0, `LH=1, `LW=2, `LBU=4, `LHU=5.
- rd  input  5  destination register.
- mem_req_valid  output  1  read request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_addr  output  ADDR_W  word-aligned read address; bits [1:0] are always 0.
- mem_rsp_valid  input  1  read data valid.
- mem_rdata  input  XLEN  read word.
- wb_valid  output  1  one-cycle writeback strobe; no backpressure.
- wb_rd  output  5  writeback register.
- wb_data  output  XLEN  extended load result.
- fault_valid  output  1  one-cycle misaligned-load strobe.
- fault_addr  output  ADDR_W  offending effective address.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE. mem_req_valid, wb_valid and fault_valid are 0. mem_addr, wb_rd, wb_data and fault_addr are 0. req_ready=1, since it is decoded from state.
- Accept: on req_valid&req_ready, latch the following, then move to CHECK:
  - ea = base + sign_extend(imm), truncated mod 2^ADDR_W, so wrap-around is silent.
  - load_control, rd, and ea[1:0].
- Unlisted load_control codes 3, 6 and 7 execute as `LB.
- CHECK, one cycle, evaluates alignment:
  - Misaligned when LH/LHU has ea[0]=1, or LW has ea[1:0]!=0. In that case go to FAULT.
  - Otherwise go to REQ.
- FAULT: for one cycle, fault_valid=1 and fault_addr=ea. No memory request and no writeback. Next state IDLE.
- REQ: mem_req_valid=1 and mem_addr={ea[ADDR_W-1:2],2'b00}, held stable until mem_req_ready. The handshake cycle moves the state to WAIT.
- WAIT: waits for mem_rsp_valid. A response in the same cycle as the request handshake is not accepted; memory must respond at least one cycle later. On mem_rsp_valid, data is extracted and registered, and the state moves to WB.
- Extraction:
  - Byte = mem_rdata[8*ea[1:0] +: 8].
  - Halfword = mem_rdata[16*ea[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- WB: for one cycle, wb_valid=1 and wb_rd=latched rd. wb_data is the extracted value, forced to 0 when rd=0. Next state IDLE.
- wb_rd and wb_data hold their last values when wb_valid=0. fault_addr holds its last value when fault_valid=0.
- Latency: accept at cycle T, CHECK T+1, mem_req_valid T+2. With ready at T+2 and response at T+3, wb_valid is at T+4. Faults appear at T+2.
- Back-to-back: req_ready returns to 1 in the cycle after WB/FAULT. A new load is never accepted while any load is in flight.
- mem_rsp_valid in IDLE, CHECK, REQ or FAULT is ignored.
- Reset mid-operation: the in-flight load is abandoned with no wb_valid or fault_valid. A stale mem_rsp_valid arriving after reset is ignored.
- Inputs base, imm, load_control and rd are sampled only at accept; later changes have no effect.

Test Plan:
- LB sign extension: base=0x1000, imm=0x003, LB, rd=5; memory returns 0x80FF_1234 -> mem_addr=0x1000, wb_rd=5, wb_data=0xFFFF_FF80, wb_valid exactly 1 cycle, at T+4 with zero-wait memory.
- LBU/LHU/LH lanes: base=0x2000, imm=0xFFE (-2), LHU; memory returns 0xBEEF_0000 -> mem_addr=0x1FFC, wb_data=0x0000_BEEF. Same address with LH -> wb_data=0xFFFF_BEEF.
- Misaligned: LW with ea=0x3002 -> fault_valid=1 for one cycle with fault_addr=0x3002, mem_req_valid never asserts, no wb_valid. LH with ea=0x3001 -> same behaviour.
- Stalls: mem_req_ready held 0 for 3 cycles, then the response arrives 4 cycles after the handshake -> mem_addr stable throughout, req_ready=0 throughout, exactly one wb_valid. A spurious mem_rsp_valid during REQ is ignored.
- rd=0 and wrap: base=0xFFFF_FFFC, imm=0x008, LW, rd=0 -> mem_addr=0x0000_0004, wb_valid=1, wb_rd=0, wb_data=0.
- Reset mid-WAIT: assert reset_n=0 while in WAIT, release, then drive mem_rsp_valid -> no wb_valid and req_ready=1. A following LW completes normally.
